// File: rtl/jt7759_adpcm.sv
// jt7759_adpcm: two-stage ADPCM nibble decoder (step lookup, then accumulate/saturate).
// Optional feature: define JT7759_SMOOTH_EN to average each new sample with the previous one.
// The step ROM carries the contents of jt7759_adpcm_steps.hex as constants, so no init file
// is needed. Every row is sign-symmetric, so only the 8 magnitudes per index are stored.

module jt7759_adpcm (
    input  logic              clk,
    input  logic              rst,
    input  logic              cendec,
    input  logic              dec_rst,
    input  logic [3:0]        dec_din,
    output logic signed [8:0] sound,
    output logic              snd_cen
);

    // Step magnitudes for one index; magnitude 0 in the low byte, magnitude 7 in the high byte
    function automatic logic [63:0] step_row(input logic [3:0] idx);
        case (idx)
            4'd0:    step_row = {8'd10,  8'd7,   8'd5,   8'd3,  8'd2,  8'd1,  8'd0,  8'd0};
            4'd1:    step_row = {8'd13,  8'd8,   8'd6,   8'd4,  8'd3,  8'd2,  8'd1,  8'd0};
            4'd2:    step_row = {8'd15,  8'd10,  8'd7,   8'd5,  8'd4,  8'd2,  8'd1,  8'd0};
            4'd3:    step_row = {8'd19,  8'd13,  8'd9,   8'd6,  8'd4,  8'd3,  8'd1,  8'd0};
            4'd4:    step_row = {8'd23,  8'd15,  8'd11,  8'd8,  8'd5,  8'd3,  8'd2,  8'd0};
            4'd5:    step_row = {8'd29,  8'd19,  8'd14,  8'd10, 8'd7,  8'd4,  8'd2,  8'd0};
            4'd6:    step_row = {8'd33,  8'd22,  8'd16,  8'd12, 8'd8,  8'd5,  8'd3,  8'd0};
            4'd7:    step_row = {8'd43,  8'd29,  8'd20,  8'd15, 8'd10, 8'd7,  8'd4,  8'd1};
            4'd8:    step_row = {8'd53,  8'd35,  8'd25,  8'd18, 8'd13, 8'd8,  8'd4,  8'd1};
            4'd9:    step_row = {8'd64,  8'd43,  8'd31,  8'd22, 8'd16, 8'd10, 8'd6,  8'd1};
            4'd10:   step_row = {8'd76,  8'd51,  8'd37,  8'd27, 8'd19, 8'd12, 8'd7,  8'd2};
            4'd11:   step_row = {8'd96,  8'd64,  8'd46,  8'd34, 8'd24, 8'd16, 8'd9,  8'd2};
            4'd12:   step_row = {8'd117, 8'd79,  8'd57,  8'd41, 8'd29, 8'd19, 8'd11, 8'd3};
            4'd13:   step_row = {8'd143, 8'd96,  8'd69,  8'd50, 8'd36, 8'd24, 8'd13, 8'd4};
            4'd14:   step_row = {8'd175, 8'd118, 8'd85,  8'd62, 8'd44, 8'd29, 8'd16, 8'd4};
            default: step_row = {8'd214, 8'd144, 8'd104, 8'd76, 8'd54, 8'd36, 8'd20, 8'd6};
        endcase
    endfunction

    // Index adjustment depends on magnitude only
    function automatic logic signed [5:0] idx_adj(input logic [2:0] mag);
        case (mag)
            3'd0, 3'd1: idx_adj = -6'sd1;
            3'd2, 3'd3: idx_adj = 6'sd0;
            3'd4:       idx_adj = 6'sd1;
            3'd5, 3'd6: idx_adj = 6'sd2;
            default:    idx_adj = 6'sd3;
        endcase
    endfunction

    logic [3:0]        idx_q, idx_d;
    logic signed [8:0] delta_q, delta_d;
    logic              valid1_q, valid1_d;
    logic signed [8:0] acc_q, acc_d;
    logic signed [8:0] sound_q, sound_d;
    logic              snd_cen_q, snd_cen_d;

    logic [63:0]       row;
    logic [7:0]        step_mag;
    logic signed [5:0] idx_sum;
    logic signed [9:0] acc_sum;
    logic signed [8:0] acc_new;
`ifdef JT7759_SMOOTH_EN
    logic signed [9:0] smooth_sum;
`endif

    // Stage 1: step lookup and clamped index update
    always_comb begin
        row      = step_row(idx_q);
        step_mag = row[{dec_din[2:0], 3'b000} +: 8];
        idx_sum  = $signed({2'b00, idx_q}) + idx_adj(dec_din[2:0]);
        idx_d    = idx_q;
        delta_d  = delta_q;
        valid1_d = 1'b0;
        if (dec_rst) begin
            idx_d   = 4'd0;
            delta_d = 9'sd0;
        end else if (cendec) begin
            delta_d  = dec_din[3] ? -$signed({1'b0, step_mag}) : $signed({1'b0, step_mag});
            valid1_d = 1'b1;
            if (idx_sum < 6'sd0) begin
                idx_d = 4'd0;
            end else if (idx_sum > 6'sd15) begin
                idx_d = 4'd15;
            end else begin
                idx_d = idx_sum[3:0];
            end
        end
    end

    // Stage 2: accumulate with saturation to the 9-bit signed range
    always_comb begin
        acc_sum = {acc_q[8], acc_q} + {delta_q[8], delta_q};
        if (acc_sum[9] != acc_sum[8]) begin
            acc_new = acc_sum[9] ? -9'sd256 : 9'sd255;
        end else begin
            acc_new = acc_sum[8:0];
        end
`ifdef JT7759_SMOOTH_EN
        smooth_sum = {acc_new[8], acc_new} + {acc_q[8], acc_q};
`endif
        acc_d     = acc_q;
        sound_d   = sound_q;
        snd_cen_d = 1'b0;
        if (dec_rst) begin
            acc_d   = 9'sd0;
            sound_d = 9'sd0;
        end else if (valid1_q) begin
            acc_d     = acc_new;
            snd_cen_d = 1'b1;
`ifdef JT7759_SMOOTH_EN
            sound_d   = 9'(smooth_sum >>> 1);
`else
            sound_d   = acc_new;
`endif
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q     <= 4'd0;
            delta_q   <= 9'sd0;
            valid1_q  <= 1'b0;
            acc_q     <= 9'sd0;
            sound_q   <= 9'sd0;
            snd_cen_q <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            delta_q   <= delta_d;
            valid1_q  <= valid1_d;
            acc_q     <= acc_d;
            sound_q   <= sound_d;
            snd_cen_q <= snd_cen_d;
        end
    end

    assign sound   = sound_q;
    assign snd_cen = snd_cen_q;

endmodule

// File: tb/tb_jt7759_adpcm.sv
// Testbench for jt7759_adpcm: reference model + scoreboard, table of single-nibble vectors,
// and hand-written sequences for saturation, index floor, decoder clear and async reset.

module tb_jt7759_adpcm;

    logic              clk = 1'b0;
    logic              rst;
    logic              cendec;
    logic              dec_rst;
    logic [3:0]        dec_din;
    logic signed [8:0] sound;
    logic              snd_cen;

    always #5 clk = ~clk;

    jt7759_adpcm dut (
        .clk     (clk),
        .rst     (rst),
        .cendec  (cendec),
        .dec_rst (dec_rst),
        .dec_din (dec_din),
        .sound   (sound),
        .snd_cen (snd_cen)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference step table and index adjustment
    int m_step [16][16] = '{
        '{0, 0, 1, 2, 3, 5, 7, 10, 0, 0, -1, -2, -3, -5, -7, -10},
        '{0, 1, 2, 3, 4, 6, 8, 13, 0, -1, -2, -3, -4, -6, -8, -13},
        '{0, 1, 2, 4, 5, 7, 10, 15, 0, -1, -2, -4, -5, -7, -10, -15},
        '{0, 1, 3, 4, 6, 9, 13, 19, 0, -1, -3, -4, -6, -9, -13, -19},
        '{0, 2, 3, 5, 8, 11, 15, 23, 0, -2, -3, -5, -8, -11, -15, -23},
        '{0, 2, 4, 7, 10, 14, 19, 29, 0, -2, -4, -7, -10, -14, -19, -29},
        '{0, 3, 5, 8, 12, 16, 22, 33, 0, -3, -5, -8, -12, -16, -22, -33},
        '{1, 4, 7, 10, 15, 20, 29, 43, -1, -4, -7, -10, -15, -20, -29, -43},
        '{1, 4, 8, 13, 18, 25, 35, 53, -1, -4, -8, -13, -18, -25, -35, -53},
        '{1, 6, 10, 16, 22, 31, 43, 64, -1, -6, -10, -16, -22, -31, -43, -64},
        '{2, 7, 12, 19, 27, 37, 51, 76, -2, -7, -12, -19, -27, -37, -51, -76},
        '{2, 9, 16, 24, 34, 46, 64, 96, -2, -9, -16, -24, -34, -46, -64, -96},
        '{3, 11, 19, 29, 41, 57, 79, 117, -3, -11, -19, -29, -41, -57, -79, -117},
        '{4, 13, 24, 36, 50, 69, 96, 143, -4, -13, -24, -36, -50, -69, -96, -143},
        '{4, 16, 29, 44, 62, 85, 118, 175, -4, -16, -29, -44, -62, -85, -118, -175},
        '{6, 20, 36, 54, 76, 104, 144, 214, -6, -20, -36, -54, -76, -104, -144, -214}
    };
    int m_adj [8] = '{-1, -1, 0, 0, 1, 2, 2, 3};
    int m_idx = 0;
    int m_acc = 0;

    typedef struct {
        int due;
        int val;
    } exp_t;
    exp_t sbq[$];
    int   got[$];

    int cen_count = 0;
    int mono_dir  = 0;
    int mono_bad  = 0;
    int last_s    = 0;

    typedef struct {
        logic [3:0] din;
        int         acc;
        int         idx;
    } vec_t;
    vec_t vecs[16];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int smooth_of(input int cur, input int prev);
`ifdef JT7759_SMOOTH_EN
        return (cur + prev) >>> 1;
`else
        return cur + 0 * prev;
`endif
    endfunction

    function automatic int model_step(input int n);
        int nidx;
        int sum;
        int prev;
        nidx = m_idx + m_adj[n & 7];
        if (nidx < 0) nidx = 0;
        if (nidx > 15) nidx = 15;
        sum = m_acc + m_step[m_idx][n];
        if (sum > 255) sum = 255;
        if (sum < -256) sum = -256;
        prev  = m_acc;
        m_acc = sum;
        m_idx = nidx;
        return smooth_of(sum, prev);
    endfunction

    // Scoreboard consumer: every snd_cen must match the oldest expected sample, on time
    always @(negedge clk) begin
        if (!rst && snd_cen) begin
            int s;
            exp_t e;
            s = sound;
            cen_count++;
            if (mono_dir > 0 && s < last_s) mono_bad++;
            if (mono_dir < 0 && s > last_s) mono_bad++;
            last_s = s;
            got.push_back(s);
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_snd_cen: got sound %0d with no sample expected", s);
            end else begin
                e = sbq.pop_front();
                check("sample", s, e.val);
                check("latency", cyc, e.due);
            end
        end
    end

    task automatic send(input int n);
        exp_t e;
        cendec  = 1'b1;
        dec_din = 4'(n);
        e.due   = cyc + 2;
        e.val   = model_step(n);
        sbq.push_back(e);
        @(posedge clk);
        #1;
        cendec = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold dec_rst for n cycles, optionally with cendec; samples not yet out are discarded
    task automatic do_dec_rst(input int n, input logic with_cen);
        while (sbq.size() > 0 && sbq[sbq.size() - 1].due > cyc) void'(sbq.pop_back());
        m_idx   = 0;
        m_acc   = 0;
        dec_rst = 1'b1;
        cendec  = with_cen;
        dec_din = 4'd7;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("dec_rst_sound", sound, 0);
            check("dec_rst_snd_cen", int'(snd_cen), 0);
        end
        dec_rst = 1'b0;
        cendec  = 1'b0;
        last_s  = 0;
    endtask

    task automatic drained(input string name);
        check(name, sbq.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cen0;

        // Single-nibble vectors from a cleared decoder (row 0 of the step table)
        vecs[0]  = '{4'd0, 0, 0};    vecs[1]  = '{4'd1, 0, 0};
        vecs[2]  = '{4'd2, 1, 0};    vecs[3]  = '{4'd3, 2, 0};
        vecs[4]  = '{4'd4, 3, 1};    vecs[5]  = '{4'd5, 5, 2};
        vecs[6]  = '{4'd6, 7, 2};    vecs[7]  = '{4'd7, 10, 3};
        vecs[8]  = '{4'd8, 0, 0};    vecs[9]  = '{4'd9, 0, 0};
        vecs[10] = '{4'd10, -1, 0};  vecs[11] = '{4'd11, -2, 0};
        vecs[12] = '{4'd12, -3, 1};  vecs[13] = '{4'd13, -5, 2};
        vecs[14] = '{4'd14, -7, 2};  vecs[15] = '{4'd15, -10, 3};

        rst     = 1'b1;
        cendec  = 1'b0;
        dec_rst = 1'b0;
        dec_din = 4'd0;
        #12;
        check("reset_sound", sound, 0);
        check("reset_snd_cen", int'(snd_cen), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single step straight out of reset
        cen0 = cen_count;
        send(7);
        idle(3);
        check("single_sound", sound, smooth_of(10, 0));
        check("single_idx", int'(dut.idx_q), 3);
        check("single_pulses", cen_count - cen0, 1);
        drained("single_drained");

        // Table of single nibbles
        for (int i = 0; i < 16; i++) begin
            do_dec_rst(1, 1'b0);
            send(int'(vecs[i].din));
            idle(3);
            check("tbl_sound", sound, smooth_of(vecs[i].acc, 0));
            check("tbl_idx", int'(dut.idx_q), vecs[i].idx);
        end
        drained("tbl_drained");

        // Index floor
        do_dec_rst(1, 1'b0);
        send(0);
        send(1);
        send(0);
        idle(3);
        check("floor_sound", sound, 0);
        check("floor_idx", int'(dut.idx_q), 0);

        // Positive saturation
        do_dec_rst(1, 1'b0);
        mono_dir = 1;
        mono_bad = 0;
        repeat (200) send(7);
        idle(3);
        mono_dir = 0;
        check("possat_sound", sound, 255);
        check("possat_idx", int'(dut.idx_q), 15);
        check("possat_monotonic", mono_bad, 0);
        drained("possat_drained");

        // Negative saturation
        do_dec_rst(1, 1'b0);
        mono_dir = -1;
        mono_bad = 0;
        repeat (200) send(15);
        idle(3);
        mono_dir = 0;
        check("negsat_sound", sound, -256);
        check("negsat_monotonic", mono_bad, 0);
        drained("negsat_drained");

        // Decoder clear colliding with cendec, accumulator at 100
        do_dec_rst(1, 1'b0);
        send(7);
        repeat (21) send(3);
        repeat (2) send(2);
        idle(3);
        check("clr_acc_before", int'(dut.acc_q), 100);
        cen0 = cen_count;
        do_dec_rst(2, 1'b1);
        idle(3);
        check("clr_no_pulse", cen_count - cen0, 0);
        check("clr_idx", int'(dut.idx_q), 0);
        send(2);
        idle(3);
        check("clr_next_sound", sound, smooth_of(1, 0));
        drained("clr_drained");

        // Dec_rst one cycle after a nibble: the in-flight sample is discarded
        do_dec_rst(1, 1'b0);
        send(7);
        cen0 = cen_count;
        do_dec_rst(1, 1'b0);
        idle(3);
        check("inflight_discard", cen_count - cen0, 0);

        // Back-to-back versus sparse
        do_dec_rst(1, 1'b0);
        got.delete();
        send(7);
        send(7);
        idle(3);
        check("b2b_count", got.size(), 2);
        if (got.size() == 2) begin
            check("b2b_first", got[0], smooth_of(10, 0));
            check("b2b_second", got[1], smooth_of(29, 10));
        end
        do_dec_rst(1, 1'b0);
        got.delete();
        send(7);
        idle(7);
        send(7);
        idle(3);
        check("sparse_count", got.size(), 2);
        if (got.size() == 2) begin
            check("sparse_first", got[0], smooth_of(10, 0));
            check("sparse_second", got[1], smooth_of(29, 10));
        end
        drained("b2b_drained");

        // Async reset mid-operation, then decode from idx 0
        repeat (5) send(15);
        send(7);
        #2;
        rst = 1'b1;
        #1;
        check("arst_sound", sound, 0);
        check("arst_snd_cen", int'(snd_cen), 0);
        check("arst_idx", int'(dut.idx_q), 0);
        check("arst_acc", int'(dut.acc_q), 0);
        sbq.delete();
        m_idx = 0;
        m_acc = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(7);
        idle(3);
        check("post_rst_sound", sound, smooth_of(10, 0));
        check("post_rst_idx", int'(dut.idx_q), 3);
        drained("final_drained");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jt7759_adpcm.md
JT7759_ADPCM -- requirements
Module: jt7759_adpcm

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset, with the ports `clk` and `rst`.
- `clk`  input  1  system clock.
- `rst`  input  1  async active-high reset.
REQ-003 The remaining ports SHALL be as follows.
- `cendec`  input  1  decoder clock enable, one `clk` wide.
- `dec_rst`  input  1  synchronous decoder clear from controller, level.
- `dec_din`  input  4  ADPCM nibble: bit3 = sign, bits2:0 = magnitude.
- `sound`  output  9  signed PCM sample.
- `snd_cen`  output  1  one-cycle strobe, high when `sound` updates.

Function
REQ-004 The step table SHALL be a 16x16 ROM of signed 9-bit values, indexed by {idx, nibble} and initialised from `jt7759_adpcm_steps.hex`.
REQ-005 Row 0 of the step table SHALL be 0,0,1,2,3,5,7,10,0,0,-1,-2,-3,-5,-7,-10.
REQ-006 Row 1 of the step table SHALL be 0,1,2,3,4,6,8,13,0,-1,-2,-3,-4,-6,-8,-13.
REQ-007 The internal state SHALL be a 4-bit step index `idx` (0..15) and a 9-bit signed accumulator `acc`.
REQ-008 Stage 1, on a `clk` edge with `cendec`=1 and `dec_rst`=0, SHALL register step[idx][dec_din] into `delta` and set `valid1`=1.
REQ-009 Stage 1 SHALL update `idx` in the same edge as REQ-008, using idx + adj[dec_din[2:0]] with adj = {-1,-1,0,0,1,2,2,3}, independent of the sign bit.
REQ-010 The `idx` update SHALL be computed in at least 6-bit signed arithmetic and then clamped to 0..15.
- No wrap-around: 0 + (-1) gives 0; 14 + 3 gives 15.
REQ-011 Stage 2, one clock after `valid1`, SHALL compute acc + delta in 10-bit signed arithmetic and saturate the result to -256..+255.
REQ-012 Stage 2 SHALL write the saturated result to `acc` and `sound`, and pulse `snd_cen` for one clock.
REQ-013 Latency SHALL be 2 clocks from the `cendec` edge to `sound` valid; with `cendec` at that edge counted as cycle 0, `sound`/`snd_cen` change at cycle 2.
REQ-014 Back-to-back `cendec` on consecutive clocks SHALL be supported.
- Each nibble uses the `idx` produced by the previous nibble.
- One sample is output per nibble; no nibble is dropped.
REQ-015 `dec_rst`=1 SHALL take effect at the next clock edge and override a simultaneous `cendec`.
- `idx`=0, `acc`=0, `delta`=0, `valid1`=0.
- `sound`=0, `snd_cen`=0.
- Any sample in flight is discarded.
REQ-016 While `dec_rst`=1, the block SHALL ignore `cendec`, hold `sound`=0 and keep `snd_cen` low.
REQ-017 Without `cendec`, all state SHALL hold its value.

Reset
REQ-018 Asserting `rst` SHALL immediately clear all state, mid-operation included.
- `idx`=0, `acc`=0, `delta`=0, `valid1`=0.
- `sound`=0, `snd_cen`=0.
REQ-019 After `rst` deasserts, the first nibble SHALL be decoded using `idx`=0.

Configuration
REQ-020 With macro `JT7759_SMOOTH_EN` defined, `sound` SHALL be (acc_new + acc_prev) >>> 1, arithmetic shift, where acc_prev is the previous `acc` (0 after reset or `dec_rst`).
- The smoothing stage SHALL add no latency.
- `snd_cen` timing SHALL be unchanged.
- `acc` itself SHALL stay unsmoothed.
REQ-021 Without `JT7759_SMOOTH_EN`, `sound` SHALL equal `acc` exactly and no smoothing logic SHALL be synthesised.

Verification
REQ-022 The bench SHALL cover these scenarios:
- Single step: after reset, nibble 7 on one `cendec` -> two clocks later `sound`=10, `snd_cen` pulses once, `idx`=3.
- Index floor: reset, then nibbles 0,1,0 -> `sound` stays 0 and `idx` stays 0, no underflow.
- Positive saturation: nibble 7 repeated 200 times -> `sound` rises monotonically, sticks at +255 and never wraps negative.
- Negative saturation: nibble 15 repeated 200 times -> `sound` sticks at -256.
- Decoder clear: `dec_rst` asserted in the same cycle as `cendec`, with `acc`=100 -> `sound`=0 next clock, no `snd_cen`, and the next nibble 2 gives `sound`=1.
- Back-to-back vs sparse: nibbles 7,7 on consecutive clocks, and the same nibbles 8 clocks apart -> identical `sound` sequence; `JT7759_SMOOTH_EN` build gives 5 then the smoothed second value.
